draw_rect_char_16x16: RTL and testbench

- Text-overlay stage of the VGA pipeline, upstream of the 16x16 character-code ROM and of the font ROM.
- Converts the incoming beam position into a character cell address (char_xy) for the code ROM, and a font ROM address from the returned char_code.
- Overlays the selected font pixel onto the incoming RGB stream; all timing signals are delayed to stay aligned with the overlay.
- Text block: 16 columns x 16 rows of 8x16-pixel glyphs, i.e. a 128x256-pixel rectangle at (XPOS, YPOS).

---
 rtl/vga_pkg.sv | 33 +++
 rtl/draw_rect_char_16x16_delay.sv | 26 ++
 rtl/draw_rect_char_16x16.sv | 138 +++++++++++++
 tb/tb_draw_rect_char_16x16.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA text-overlay constants and the glyph pixel selector used by the
// character-rectangle overlay stage.
package vga_pkg;

  localparam int CNT_W       = 11;
  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int TEXT_COLS   = 16;
  localparam int TEXT_ROWS   = 16;
  localparam int FONT_ADDR_W = 11;
  localparam int CHAR_CODE_W = 7;
  localparam int RGB_W       = 12;

  localparam int TEXT_W_PX = CHAR_W * TEXT_COLS;
  localparam int TEXT_H_PX = CHAR_H * TEXT_ROWS;

  // Timing signals that travel together through the overlay pipeline.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } vga_timing_t;

  // Font rows are stored MSB-first: column 0 is the leftmost pixel.
  function automatic logic glyph_pixel(input logic [CHAR_W-1:0] row,
                                       input logic [2:0]        col);
    return row[3'd7 - col];
  endfunction

endpackage

// File: rtl/draw_rect_char_16x16_delay.sv
// Generic shift-register delay line with asynchronous active-low reset.
// Used for the timing/rgb alignment and the in_rect/column side pipe.
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char_16x16.sv
// 16x16-character text overlay: beam position -> code ROM cell -> font ROM
// row -> pixel overlay, 4-cycle aligned. Opaque background with DRAW_RECT_CHAR_BG_EN.
module draw_rect_char_16x16
  import vga_pkg::*;
#(
  parameter int unsigned      XPOS       = 64,
  parameter int unsigned      YPOS       = 64,
  parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       hcount_in,
  input  logic [CNT_W-1:0]       vcount_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   hblnk_in,
  input  logic                   vblnk_in,
  input  logic [RGB_W-1:0]       rgb_in,
  output logic [7:0]             char_xy,
  input  logic [CHAR_CODE_W-1:0] char_code,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [CHAR_W-1:0]      font_data,
  output logic [CNT_W-1:0]       hcount_out,
  output logic [CNT_W-1:0]       vcount_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   hblnk_out,
  output logic                   vblnk_out,
  output logic [RGB_W-1:0]       rgb_out
);

`ifdef DRAW_RECT_CHAR_BG_EN
  localparam logic BG_EN = 1'b1;
`else
  localparam logic BG_EN = 1'b0;
`endif

  localparam logic [CNT_W:0] X_LO = (CNT_W+1)'(XPOS);
  localparam logic [CNT_W:0] X_HI = (CNT_W+1)'(XPOS + TEXT_W_PX);
  localparam logic [CNT_W:0] Y_LO = (CNT_W+1)'(YPOS);
  localparam logic [CNT_W:0] Y_HI = (CNT_W+1)'(YPOS + TEXT_H_PX);

  // Only the low bits of the wrapped offsets address the 128x256 block.
  logic [6:0] rel_x;
  logic [7:0] rel_y;
  logic       in_rect;

  assign rel_x   = 7'(hcount_in - CNT_W'(XPOS));
  assign rel_y   = 8'(vcount_in - CNT_W'(YPOS));
  assign in_rect = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                   ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);

  // S1: cell address to the code ROM, glyph line held for S2
  logic [3:0] line_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy <= '0;
      line_p1 <= '0;
    end else begin
      char_xy <= {rel_y[7:4], rel_x[6:3]};
      line_p1 <= rel_y[3:0];
    end
  end

  // S2: font ROM address from the combinational char_code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) font_addr <= '0;
    else        font_addr <= {char_code, line_p1};
  end

  // Side pipe: rectangle flag and glyph column, aligned with font_data at S3
  logic       in_rect_p3;
  logic [2:0] col_p3;

  delay #(.WIDTH(4), .CLK_DEL(3)) u_side_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_rect, rel_x[2:0]}),
    .dout ({in_rect_p3, col_p3})
  );

  // Blanking and colour reach S3 for the overlay decision
  logic             hblnk_p3;
  logic             vblnk_p3;
  logic [RGB_W-1:0] rgb_p3;

  delay #(.WIDTH(RGB_W + 2), .CLK_DEL(3)) u_video_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hblnk_in, vblnk_in, rgb_in}),
    .dout ({hblnk_p3, vblnk_p3, rgb_p3})
  );

  // Counts, syncs and blanks go straight through the full 4-cycle delay
  vga_timing_t timing_in;
  vga_timing_t timing_p4;

  assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                       hsync: hsync_in, vsync: vsync_in,
                       hblnk: hblnk_in, vblnk: vblnk_in};

  delay #(.WIDTH($bits(vga_timing_t)), .CLK_DEL(4)) u_timing_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (timing_in),
    .dout (timing_p4)
  );

  assign hcount_out = timing_p4.hcount;
  assign vcount_out = timing_p4.vcount;
  assign hsync_out  = timing_p4.hsync;
  assign vsync_out  = timing_p4.vsync;
  assign hblnk_out  = timing_p4.hblnk;
  assign vblnk_out  = timing_p4.vblnk;

  // S3: font_data is valid now; pick the pixel under the beam
  logic pixel_p3;

  assign pixel_p3 = glyph_pixel(font_data, col_p3);

  // S4: registered overlay; blanking always passes the incoming colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= '0;
    end else if (hblnk_p3 || vblnk_p3) begin
      rgb_out <= rgb_p3;
    end else if (in_rect_p3 && pixel_p3) begin
      rgb_out <= TEXT_COLOR;
    end else if (in_rect_p3 && BG_EN) begin
      rgb_out <= BG_COLOR;
    end else begin
      rgb_out <= rgb_p3;
    end
  end

endmodule

// File: tb/tb_draw_rect_char_16x16.sv
// Scoreboard bench for draw_rect_char_16x16 with behavioural code/font ROMs;
// honours DRAW_RECT_CHAR_BG_EN in its reference model.
module tb_draw_rect_char_16x16;

  localparam int          XPOS       = 64;
  localparam int          YPOS       = 64;
  localparam logic [11:0] TEXT_COLOR = 12'hFFF;
  localparam logic [11:0] BG_COLOR   = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [6:0] char_mem [256];
  logic [7:0] font_mem [2048];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  flags;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int          due;
    logic [10:0] val;
  } addr_t;

  out_t  out_q[$];
  addr_t xy_q[$];
  addr_t fa_q[$];

  draw_rect_char_16x16 #(
    .XPOS(XPOS), .YPOS(YPOS), .TEXT_COLOR(TEXT_COLOR), .BG_COLOR(BG_COLOR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .font_data(font_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational code ROM, synchronous font ROM
  assign char_code = char_mem[char_xy];
  always @(posedge clk) font_data <= font_mem[font_addr];

  // Reference model in plain integer arithmetic
  function automatic int wrap11(input int v);
    return ((v % 2048) + 2048) % 2048;
  endfunction

  function automatic bit m_in_rect(input int h, input int v);
    return (h >= XPOS) && (h < XPOS + 128) && (v >= YPOS) && (v < YPOS + 256);
  endfunction

  function automatic int m_xy(input int h, input int v);
    int rx = wrap11(h - XPOS);
    int ry = wrap11(v - YPOS);
    return ((ry / 16) % 16) * 16 + (rx / 8) % 16;
  endfunction

  function automatic int m_fa(input int h, input int v);
    return int'(char_mem[m_xy(h, v)]) * 16 + wrap11(v - YPOS) % 16;
  endfunction

  function automatic logic [11:0] m_rgb(input int h, input int v, input bit hb,
                                        input bit vb, input logic [11:0] rgb);
    int   rx  = wrap11(h - XPOS) % 8;
    logic [7:0] row = font_mem[m_fa(h, v)];
    bit   pix = row[7 - rx];
    if (hb || vb) return rgb;
    if (m_in_rect(h, v)) begin
      if (pix) return TEXT_COLOR;
`ifdef DRAW_RECT_CHAR_BG_EN
      return BG_COLOR;
`endif
    end
    return rgb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs,
                       input bit hb, input bit vb, input logic [11:0] rgb,
                       input bit use_exp, input logic [11:0] exp_rgb);
    out_t  o;
    addr_t a;
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    o.due   = cyc + 4;
    o.hc    = 11'(h);
    o.vc    = 11'(v);
    o.flags = {hs, vs, hb, vb};
    o.rgb   = use_exp ? exp_rgb : m_rgb(h, v, hb, vb, rgb);
    out_q.push_back(o);
    a.due = cyc + 1;
    a.val = 11'(m_xy(h, v));
    xy_q.push_back(a);
    a.due = cyc + 2;
    a.val = 11'(m_fa(h, v));
    fa_q.push_back(a);
  endtask

  // Blanked pixels flush the ROM-dependent pipeline before ROM contents change
  task automatic drain();
    for (int i = 0; i < 4; i++) drive(300, 20, 1'b0, 1'b0, 1'b1, 1'b0, 12'h5A5, 1'b0, '0);
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_rgb"}, 64'(rgb_out), 64'd0);
    check({tag, "_timing"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                                 hblnk_out, vblnk_out}), 64'd0);
    check({tag, "_char_xy"}, 64'(char_xy), 64'd0);
    check({tag, "_font_addr"}, 64'(font_addr), 64'd0);
  endtask

  task automatic random_pixels(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(40, 210), $urandom_range(40, 340),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            12'($urandom), 1'b0, '0);
  endtask

  // Monitor: pops whatever is due this cycle and compares
  always @(negedge clk) begin : monitor
    out_t  o;
    addr_t a;
    while (xy_q.size() > 0 && xy_q[0].due <= cyc) begin
      a = xy_q.pop_front();
      check("char_xy", 64'(char_xy), 64'(a.val[7:0]));
    end
    while (fa_q.size() > 0 && fa_q[0].due <= cyc) begin
      a = fa_q.pop_front();
      check("font_addr", 64'(font_addr), 64'(a.val));
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      o = out_q.pop_front();
      check("rgb_out", 64'(rgb_out), 64'(o.rgb));
      check("hcount_out", 64'(hcount_out), 64'(o.hc));
      check("vcount_out", 64'(vcount_out), 64'(o.vc));
      check("sync_blank", 64'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'(o.flags));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eh [8];
    int ev [8];
    bit ein [8];
    for (int i = 0; i < 256; i++) char_mem[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2 check_reset_now("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Address mapping and glyph pixel selection at a known cell
    drain();
    char_mem[8'h15]   = 7'h61;
    font_mem[11'h617] = 8'b0001_0000;
    drive(107, 87, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, TEXT_COLOR);
`ifdef DRAW_RECT_CHAR_BG_EN
    drive(106, 87, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h000);
`else
    drive(106, 87, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b1, 12'h0F0);
`endif
    drive(107, 87, 1'b0, 1'b0, 1'b1, 1'b0, 12'hABC, 1'b1, 12'hABC);
    drive(107, 87, 1'b1, 1'b0, 1'b0, 1'b1, 12'h456, 1'b1, 12'h456);

    // Rectangle edges with an all-ones glyph row under each point
    eh  = '{63, 192, 64, 191, 100, 100, 100, 100};
    ev  = '{100, 100, 100, 100, 63, 320, 64, 319};
    ein = '{0, 0, 1, 1, 0, 0, 1, 1};
    drain();
    for (int i = 0; i < 8; i++) font_mem[m_fa(eh[i], ev[i])] = 8'hFF;
    for (int i = 0; i < 8; i++)
      drive(eh[i], ev[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C3, 1'b1,
            ein[i] ? TEXT_COLOR : 12'h3C3);

    random_pixels(400);

    // Reset in the middle of a line flushes the pipeline at once
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_now("midreset");
    out_q.delete();
    xy_q.delete();
    fa_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_rgb_blank", 64'({rgb_out, hblnk_out, vblnk_out}), 64'd0);

    random_pixels(300);

    repeat (6) @(negedge clk);
    total++;
    if (out_q.size() != 0 || xy_q.size() != 0 || fa_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries expected 0",
               out_q.size() + xy_q.size() + fa_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
